// File: rtl/audio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : audio_ctrl
// Description : Register front end for the PCM audio path. Decodes the CTRL,
//               RATE, DATA and IRQ registers, paces playback with a periodic
//               next_sample strobe, forwards data bytes into the audio FIFO
//               with sticky overflow tracking, stages sample-rate changes onto
//               sample boundaries and raises the FIFO-low (AFLOW) interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_ctrl #(
    parameter int DIVIDER = 512            // clock cycles per next_sample, 4..65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] reg_addr_i,
    input  logic [7:0] reg_wrdata_i,
    input  logic       reg_write_i,
    output logic [7:0] reg_rddata_o,
    input  logic       fifo_full_i,
    input  logic       fifo_almost_empty_i,
    input  logic       fifo_empty_i,
    output logic       next_sample_o,
    output logic [7:0] sample_rate_o,
    output logic       mode_stereo_o,
    output logic       mode_16bit_o,
    output logic [3:0] volume_o,
    output logic       fifo_reset_o,
    output logic [7:0] fifo_wrdata_o,
    output logic       fifo_write_o,
    output logic       irq_aflow_o
);

    localparam logic [1:0]  ADDR_CTRL = 2'd0;
    localparam logic [1:0]  ADDR_RATE = 2'd1;
    localparam logic [1:0]  ADDR_DATA = 2'd2;
    localparam logic [1:0]  ADDR_IRQ  = 2'd3;
    localparam logic [15:0] DIV_LOAD  = 16'(DIVIDER - 1);
    localparam logic [7:0]  RATE_MAX  = 8'd128;

    // Registered state and next-state values
    logic [15:0] div_q,         div_d;
    logic [7:0]  rate_pend_q,   rate_pend_d;
    logic [7:0]  rate_q,        rate_d;
    logic        mode_stereo_q, mode_stereo_d;
    logic        mode_16bit_q,  mode_16bit_d;
    logic [3:0]  volume_q,      volume_d;
    logic        fifo_reset_q,  fifo_reset_d;
    logic [7:0]  fifo_wrdata_q, fifo_wrdata_d;
    logic        fifo_write_q,  fifo_write_d;
    logic        ovf_q,         ovf_d;
    logic        aflow_ien_q,   aflow_ien_d;
    logic        irq_q,         irq_d;

    logic        tick;
    logic        wr_ctrl, wr_rate, wr_data, wr_irq;
    logic [7:0]  rate_clamped;
    logic        wrdata_unused;

    // CTRL bit6 carries no function
    assign wrdata_unused = reg_wrdata_i[6];

    // Strobe is decoded straight from the counter so it is 0 during reset
    assign tick = (div_q == 16'd0);

    assign wr_ctrl = reg_write_i && (reg_addr_i == ADDR_CTRL);
    assign wr_rate = reg_write_i && (reg_addr_i == ADDR_RATE);
    assign wr_data = reg_write_i && (reg_addr_i == ADDR_DATA);
    assign wr_irq  = reg_write_i && (reg_addr_i == ADDR_IRQ);

    assign rate_clamped = (reg_wrdata_i > RATE_MAX) ? RATE_MAX : reg_wrdata_i;

    // Next-state logic for divider, registers, FIFO strobes and interrupt
    always_comb begin
        div_d         = tick ? DIV_LOAD : (div_q - 16'd1);
        rate_pend_d   = rate_pend_q;
        rate_d        = rate_q;
        mode_stereo_d = mode_stereo_q;
        mode_16bit_d  = mode_16bit_q;
        volume_d      = volume_q;
        fifo_reset_d  = 1'b0;
        fifo_wrdata_d = fifo_wrdata_q;
        fifo_write_d  = 1'b0;
        ovf_d         = ovf_q;
        aflow_ien_d   = aflow_ien_q;

        // A rate written during the tick cycle takes effect on that same edge
        if (wr_rate) begin
            rate_pend_d = rate_clamped;
        end
        if (tick) begin
            rate_d = wr_rate ? rate_clamped : rate_pend_q;
        end

        if (wr_ctrl) begin
            mode_16bit_d  = reg_wrdata_i[5];
            mode_stereo_d = reg_wrdata_i[4];
            volume_d      = reg_wrdata_i[3:0];
            // Flush also discards the overflow history
            if (reg_wrdata_i[7]) begin
                fifo_reset_d = 1'b1;
                ovf_d        = 1'b0;
            end
        end

        // fifo_full is sampled in the write cycle itself
        if (wr_data) begin
            if (fifo_full_i) begin
                ovf_d = 1'b1;
            end else begin
                fifo_write_d  = 1'b1;
                fifo_wrdata_d = reg_wrdata_i;
            end
        end

        if (wr_irq) begin
            aflow_ien_d = reg_wrdata_i[0];
            if (reg_wrdata_i[1]) begin
                ovf_d = 1'b0;
            end
        end

        irq_d = aflow_ien_q && fifo_almost_empty_i && (rate_q != 8'd0);
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= DIV_LOAD;
            rate_pend_q   <= 8'd0;
            rate_q        <= 8'd0;
            mode_stereo_q <= 1'b0;
            mode_16bit_q  <= 1'b0;
            volume_q      <= 4'd0;
            fifo_reset_q  <= 1'b0;
            fifo_wrdata_q <= 8'd0;
            fifo_write_q  <= 1'b0;
            ovf_q         <= 1'b0;
            aflow_ien_q   <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            div_q         <= div_d;
            rate_pend_q   <= rate_pend_d;
            rate_q        <= rate_d;
            mode_stereo_q <= mode_stereo_d;
            mode_16bit_q  <= mode_16bit_d;
            volume_q      <= volume_d;
            fifo_reset_q  <= fifo_reset_d;
            fifo_wrdata_q <= fifo_wrdata_d;
            fifo_write_q  <= fifo_write_d;
            ovf_q         <= ovf_d;
            aflow_ien_q   <= aflow_ien_d;
            irq_q         <= irq_d;
        end
    end

    // Combinational register read mux
    always_comb begin
        reg_rddata_o = 8'd0;
        case (reg_addr_i)
            ADDR_CTRL: reg_rddata_o = {fifo_full_i, fifo_empty_i, mode_16bit_q,
                                       mode_stereo_q, volume_q};
            ADDR_RATE: reg_rddata_o = rate_pend_q;
            ADDR_DATA: reg_rddata_o = 8'd0;
            ADDR_IRQ:  reg_rddata_o = {5'd0, fifo_almost_empty_i, ovf_q, aflow_ien_q};
            default:   reg_rddata_o = 8'd0;
        endcase
    end

    assign next_sample_o = tick;
    assign sample_rate_o = rate_q;
    assign mode_stereo_o = mode_stereo_q;
    assign mode_16bit_o  = mode_16bit_q;
    assign volume_o      = volume_q;
    assign fifo_reset_o  = fifo_reset_q;
    assign fifo_wrdata_o = fifo_wrdata_q;
    assign fifo_write_o  = fifo_write_q;
    assign irq_aflow_o   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_ctrl
// Description : Directed self-checking bench for audio_ctrl (DIVIDER = 512).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] reg_addr = 2'd0;
    logic [7:0] reg_wrdata = 8'd0;
    logic       reg_write = 1'b0;
    logic [7:0] reg_rddata;
    logic       fifo_full = 1'b0;
    logic       fifo_almost_empty = 1'b0;
    logic       fifo_empty = 1'b0;
    logic       next_sample;
    logic [7:0] sample_rate;
    logic       mode_stereo;
    logic       mode_16bit;
    logic [3:0] volume;
    logic       fifo_reset;
    logic [7:0] fifo_wrdata;
    logic       fifo_write;
    logic       irq_aflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;    // cycle index since reset release, first cycle = 1

    audio_ctrl #(.DIVIDER(512)) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .reg_addr_i          (reg_addr),
        .reg_wrdata_i        (reg_wrdata),
        .reg_write_i         (reg_write),
        .reg_rddata_o        (reg_rddata),
        .fifo_full_i         (fifo_full),
        .fifo_almost_empty_i (fifo_almost_empty),
        .fifo_empty_i        (fifo_empty),
        .next_sample_o       (next_sample),
        .sample_rate_o       (sample_rate),
        .mode_stereo_o       (mode_stereo),
        .mode_16bit_o        (mode_16bit),
        .volume_o            (volume),
        .fifo_reset_o        (fifo_reset),
        .fifo_wrdata_o       (fifo_wrdata),
        .fifo_write_o        (fifo_write),
        .irq_aflow_o         (irq_aflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        reg_addr   = a;
        reg_wrdata = d;
        reg_write  = 1'b1;
        step();
        reg_write  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 1;
    endtask

    task automatic wait_tick();
        for (int n = 0; n < 600 && !next_sample; n++) step();
        chk("tick_wait", {15'd0, next_sample}, 16'd1);
    endtask

    initial begin
        int pulses;

        // ---------------- Reset values and divider period ----------------
        do_reset();
        reg_addr = 2'd0;
        #1;
        chk("rst_rd_ctrl", {8'd0, reg_rddata}, 16'h00);
        chk("rst_rate",    {8'd0, sample_rate}, 16'h00);
        chk("rst_modes",   {12'd0, mode_16bit, mode_stereo, fifo_reset, fifo_write}, 16'h0);
        chk("rst_vol_irq", {11'd0, volume, irq_aflow}, 16'h0);
        pulses = 0;
        while (cyc <= 2000) begin
            if (next_sample) pulses++;
            chk("next_sample", {15'd0, next_sample}, {15'd0, (cyc % 512) == 0});
            step();
        end
        chk("pulse_count", 16'(pulses), 16'd3);

        // ---------------- Rate staging ----------------
        do_reset();
        while (cyc < 100) step();
        wr(2'd1, 8'h40);
        chk("rate_pend_rd", {8'd0, reg_rddata}, 16'h40);
        chk("rate_hold_101", {8'd0, sample_rate}, 16'h00);
        while (cyc < 512) step();
        chk("tick_512", {15'd0, next_sample}, 16'd1);
        chk("rate_hold_512", {8'd0, sample_rate}, 16'h00);
        step();
        chk("rate_act_513", {8'd0, sample_rate}, 16'h40);
        wr(2'd1, 8'hC8);
        chk("rate_clamp_rd", {8'd0, reg_rddata}, 16'h80);
        chk("rate_act_kept", {8'd0, sample_rate}, 16'h40);

        // ---------------- Rate write in the tick cycle ----------------
        while (cyc < 1024) step();
        chk("tick_1024", {15'd0, next_sample}, 16'd1);
        wr(2'd1, 8'h20);
        chk("rate_in_tick", {8'd0, sample_rate}, 16'h20);
        chk("rate_in_tick_pend", {8'd0, reg_rddata}, 16'h20);

        // ---------------- DATA forwarding and overflow ----------------
        fifo_full = 1'b0;
        wr(2'd2, 8'hA5);
        chk("data_wr", {15'd0, fifo_write}, 16'd1);
        chk("data_byte", {8'd0, fifo_wrdata}, 16'hA5);
        chk("data_rd0", {8'd0, reg_rddata}, 16'h00);
        step();
        chk("data_wr_1cyc", {15'd0, fifo_write}, 16'd0);
        fifo_full = 1'b1;
        wr(2'd2, 8'h5A);
        fifo_full = 1'b0;
        chk("drop_no_wr", {15'd0, fifo_write}, 16'd0);
        chk("drop_byte_kept", {8'd0, fifo_wrdata}, 16'hA5);
        reg_addr = 2'd3;
        #1;
        chk("ovf_set_rd", {8'd0, reg_rddata}, 16'h02);
        wr(2'd3, 8'h02);
        chk("ovf_clr_rd", {8'd0, reg_rddata}, 16'h00);

        // Back-to-back DATA writes
        reg_addr   = 2'd2;
        reg_wrdata = 8'h11;
        reg_write  = 1'b1;
        step();
        chk("b2b_wr1", {15'd0, fifo_write}, 16'd1);
        chk("b2b_byte1", {8'd0, fifo_wrdata}, 16'h11);
        reg_wrdata = 8'h22;
        step();
        reg_write  = 1'b0;
        chk("b2b_wr2", {15'd0, fifo_write}, 16'd1);
        chk("b2b_byte2", {8'd0, fifo_wrdata}, 16'h22);
        step();
        chk("b2b_end", {15'd0, fifo_write}, 16'd0);

        // ---------------- CTRL write with flush ----------------
        fifo_full = 1'b1;
        wr(2'd2, 8'h33);
        fifo_full  = 1'b0;
        fifo_empty = 1'b1;
        reg_addr   = 2'd3;
        #1;
        chk("ovf_pre_ctrl", {8'd0, reg_rddata}, 16'h02);
        wr(2'd0, 8'hB7);
        chk("ctrl_fifo_reset", {15'd0, fifo_reset}, 16'd1);
        chk("ctrl_modes", {14'd0, mode_16bit, mode_stereo}, 16'h3);
        chk("ctrl_volume", {12'd0, volume}, 16'h7);
        chk("ctrl_rd", {8'd0, reg_rddata}, 16'h77);
        reg_addr = 2'd3;
        #1;
        chk("ctrl_ovf_clr", {8'd0, reg_rddata}, 16'h00);
        step();
        chk("ctrl_reset_1cyc", {15'd0, fifo_reset}, 16'd0);
        fifo_empty = 1'b0;

        // ---------------- AFLOW interrupt ----------------
        wr(2'd3, 8'h01);
        wr(2'd1, 8'h80);
        wait_tick();
        step();
        chk("irq_rate80", {8'd0, sample_rate}, 16'h80);
        fifo_almost_empty = 1'b1;
        reg_addr = 2'd3;
        #1;
        chk("irq_rd", {8'd0, reg_rddata}, 16'h05);
        chk("irq_lag", {15'd0, irq_aflow}, 16'd0);
        step();
        chk("irq_set", {15'd0, irq_aflow}, 16'd1);
        wr(2'd1, 8'h00);
        wait_tick();
        chk("irq_still_at_tick", {15'd0, irq_aflow}, 16'd1);
        step();
        chk("irq_rate0", {8'd0, sample_rate}, 16'h00);
        chk("irq_lag_drop", {15'd0, irq_aflow}, 16'd1);
        step();
        chk("irq_dropped", {15'd0, irq_aflow}, 16'd0);

        // ---------------- Asynchronous reset mid-run ----------------
        wr(2'd1, 8'h10);
        wait_tick();
        step();
        wr(2'd2, 8'h99);
        chk("pre_rst_wr", {15'd0, fifo_write}, 16'd1);
        chk("pre_rst_irq", {15'd0, irq_aflow}, 16'd1);
        #2;
        rst_n    = 1'b0;
        reg_addr = 2'd1;
        #1;
        chk("arst_strobes", {13'd0, fifo_write, fifo_reset, next_sample}, 16'h0);
        chk("arst_rate", {8'd0, sample_rate}, 16'h00);
        chk("arst_modes", {10'd0, mode_16bit, mode_stereo, volume}, 16'h00);
        chk("arst_irq", {15'd0, irq_aflow}, 16'd0);
        chk("arst_byte", {8'd0, fifo_wrdata}, 16'h00);
        chk("arst_rd", {8'd0, reg_rddata}, 16'h00);
        fifo_almost_empty = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 1;
        while (cyc < 511) step();
        chk("restart_511", {15'd0, next_sample}, 16'd0);
        step();
        chk("restart_512", {15'd0, next_sample}, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_ctrl.md
# audio_ctrl

Register-facing controller that configures and sequences the PCM audio datapath. It decodes the four audio registers from the CPU bus, paces sample playback with a periodic `next_sample` strobe, and forwards data writes into the audio FIFO with overflow tracking. It also raises the FIFO-low (AFLOW) interrupt and applies sample-rate changes only on sample boundaries, so the PCM rate accumulator never sees a mid-period change. It sits between the bus register decoder and the `pcm` block.

## Interface
- `DIVIDER`, 512: clock cycles per `next_sample` strobe (25 MHz / 512 = 48828.125 Hz); legal range 4..65535.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reg_addr`  in  2  register select: 0 CTRL, 1 RATE, 2 DATA, 3 IRQ.
- `reg_wrdata`  in  8  bus write data.
- `reg_write`  in  1  single-cycle write strobe.
- `reg_rddata`  out  8  combinational read data for `reg_addr`.
- `fifo_full`, `fifo_almost_empty`, `fifo_empty`  in  1 each  status from `pcm`.
- `next_sample`  out  1  one-cycle pacing strobe to `pcm`.
- `sample_rate`  out  8  active rate, 0..128.
- `mode_stereo`, `mode_16bit`  out  1 each  format control.
- `volume`  out  4  volume index.
- `fifo_reset`  out  1  one-cycle FIFO flush pulse.
- `fifo_wrdata`  out  8  byte to FIFO.
- `fifo_write`  out  1  one-cycle FIFO write strobe.
- `irq_aflow`  out  1  level interrupt, active high.

## Operation
- **Divider.** 16-bit down-counter loads `DIVIDER-1`. `next_sample` = 1 in the cycle the counter reads 0; the counter reloads on the same edge. The divider free-runs, independent of register traffic.
- **CTRL (0).**
  - Write: bit7 = 1 issues `fifo_reset`. Bit5 sets `mode_16bit`, bit4 sets `mode_stereo`, bits3:0 set `volume`. Bit6 is ignored.
  - Read: {`fifo_full`, `fifo_empty`, `mode_16bit`, `mode_stereo`, `volume`}.
- **RATE (1).**
  - Write loads `rate_pending`. Values above 128 are clamped to 128.
  - `sample_rate` (active) copies `rate_pending` on the edge ending a `next_sample` cycle.
  - A RATE write in a tick cycle loads both pending and active with the clamped value on that edge.
  - Read returns `rate_pending`.
- **DATA (2).**
  - Write with `fifo_full` = 0: registers the byte to `fifo_wrdata` and pulses `fifo_write`.
  - Write with `fifo_full` = 1: the byte is dropped, no `fifo_write`, and sticky `ovf` is set.
  - Read returns 0.
- **IRQ (3).**
  - Write: bit0 sets `aflow_ien`; bit1 = 1 clears `ovf`.
  - Read: {5'b0, `fifo_almost_empty`, `ovf`, `aflow_ien`}.
- **Interrupt.** `irq_aflow` = `aflow_ien` & `fifo_almost_empty` & (`sample_rate` != 0), registered.
- **FIFO reset.** A `fifo_reset` pulse also clears `ovf`. A DATA write in the cycle after a CTRL reset write is forwarded normally; it lands after the flush.

## Timing
- Reset values: all outputs and registers 0, except the divider counter = `DIVIDER-1`. `fifo_reset`, `fifo_write` and `next_sample` are held 0 while `rst_n` = 0.
- First `next_sample` occurs in the `DIVIDER`th cycle after `rst_n` deasserts. Period is exactly `DIVIDER` cycles.
- CTRL and IRQ field writes are visible on outputs and `reg_rddata` the cycle after `reg_write`.
- `fifo_reset` and `fifo_write` assert exactly one cycle after the strobing `reg_write` cycle, for exactly one cycle.
- `fifo_full` is sampled in the `reg_write` cycle.
- `ovf` sets on the edge ending the dropped write.
- `irq_aflow` lags its inputs by one cycle.
- `rst_n` asserted mid-operation clears everything asynchronously. Any pending `fifo_write` is lost, and the divider restarts from full count.
- Back-to-back DATA writes, one per cycle, produce one `fifo_write` per cycle with no gaps.

## Test plan
- **Divider:** reset, run 2000 cycles with `DIVIDER` = 512 -> `next_sample` pulses at cycles 512, 1024, 1536, each one cycle wide.
- **Rate staging:** RATE write 0x40 at cycle 100 -> `sample_rate` stays 0 through cycle 512 and becomes 0x40 at cycle 513. RATE write 0xC8 -> RATE reads 0x80.
- **Rate in tick cycle:** RATE write 0x20 coinciding with a `next_sample` cycle -> `sample_rate` = 0x20 the next cycle.
- **Overflow:** DATA write 0xA5 with `fifo_full` = 0 -> `fifo_write` and `fifo_wrdata` = 0xA5 one cycle later. DATA write with `fifo_full` = 1 -> no `fifo_write`, and IRQ reads 0x02 after the write. IRQ write 0x02 -> reads 0x00.
- **CTRL:** CTRL write 0xB7 -> `fifo_reset` pulses once, `mode_16bit` = 1, `mode_stereo` = 1, `volume` = 7, `ovf` cleared. CTRL reads {`fifo_full`, `fifo_empty`, 6'h37}.
- **Interrupt:** `aflow_ien` = 1, `sample_rate` = 0x80, drive `fifo_almost_empty` high -> `irq_aflow` = 1 one cycle later. Then write RATE 0 and wait for a tick -> `irq_aflow` drops the cycle after `sample_rate` reaches 0. Assert `rst_n` = 0 mid-run -> all outputs 0 immediately.
